// File: rtl/complex_nr_acc.sv
// Complex dot-product accumulator sitting behind the complex multiplier.
// Sums groups of len signed complex products and presents each sum on a val/rdy handshake.
module complex_nr_acc #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 8,
    parameter int ACC_W  = 24
) (
    input  logic                     clk,
    input  logic                     sw_rst,
    input  logic [CNT_W-1:0]         len,
    input  logic                     res_val,
    output logic                     res_rdy,
    input  logic signed [DATA_W-1:0] res_re,
    input  logic signed [DATA_W-1:0] resm,
    output logic                     acc_val,
    input  logic                     acc_rdy,
    output logic signed [ACC_W-1:0]  acc_re,
    output logic signed [ACC_W-1:0]  acc_im,
    output logic                     busy
);

    typedef enum logic [0:0] {
        ST_ACC = 1'b0,
        ST_OUT = 1'b1
    } state_t;

    state_t                   state_r;
    logic [CNT_W-1:0]         cnt_r;
    logic [CNT_W-1:0]         len_q_r;
    logic signed [ACC_W-1:0]  acc_re_r;
    logic signed [ACC_W-1:0]  acc_im_r;
    logic                     acc_val_r;
    logic                     busy_r;

    logic [CNT_W-1:0]         len_eff_s;
    logic [CNT_W-1:0]         term_s;
    logic                     last_s;
    logic signed [ACC_W-1:0]  ext_re_s;
    logic signed [ACC_W-1:0]  ext_im_s;

    // Terminal index wraps modulo 2^CNT_W so len=0 means a full 2^CNT_W group.
    always_comb begin
        len_eff_s = len_q_r;
        if (cnt_r == {CNT_W{1'b0}}) begin
            len_eff_s = len;
        end else begin
            len_eff_s = len_q_r;
        end
        term_s   = len_eff_s - CNT_W'(1);
        last_s   = (cnt_r == term_s);
        ext_re_s = {{(ACC_W-DATA_W){res_re[DATA_W-1]}}, res_re};
        ext_im_s = {{(ACC_W-DATA_W){resm[DATA_W-1]}}, resm};
    end

    // Collect/present state machine; reset overrides any handshake in the same cycle.
    always_ff @(posedge clk) begin
        if (sw_rst) begin
            state_r   <= ST_ACC;
            cnt_r     <= {CNT_W{1'b0}};
            len_q_r   <= {CNT_W{1'b0}};
            acc_re_r  <= {ACC_W{1'b0}};
            acc_im_r  <= {ACC_W{1'b0}};
            acc_val_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_ACC: begin
                    if (res_val) begin
                        if (cnt_r == {CNT_W{1'b0}}) begin
                            len_q_r  <= len;
                            acc_re_r <= ext_re_s;
                            acc_im_r <= ext_im_s;
                        end else begin
                            acc_re_r <= acc_re_r + ext_re_s;
                            acc_im_r <= acc_im_r + ext_im_s;
                        end
                        if (last_s) begin
                            cnt_r     <= {CNT_W{1'b0}};
                            busy_r    <= 1'b0;
                            state_r   <= ST_OUT;
                            acc_val_r <= 1'b1;
                        end else begin
                            cnt_r  <= cnt_r + CNT_W'(1);
                            busy_r <= 1'b1;
                        end
                    end
                end
                ST_OUT: begin
                    if (acc_rdy) begin
                        state_r   <= ST_ACC;
                        acc_val_r <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= ST_ACC;
                    acc_val_r <= 1'b0;
                end
            endcase
        end
    end

    assign res_rdy = (state_r == ST_ACC) && !sw_rst;
    assign acc_val = acc_val_r;
    assign acc_re  = acc_re_r;
    assign acc_im  = acc_im_r;
    assign busy    = busy_r;

endmodule
